// File: rtl/ic_gate_ctrl_if.sv
// ---------------------------------------------------------------------------
// ic_gate_ctrl_if
//   Groups the register/CPU-side request signals, the input_capture counter
//   feedback and the gate sequencer outputs into one bundle. The signal names
//   keep their i_/o_ prefixes as seen from the gate controller, so a
//   controller input is always called i_* whichever side holds the bundle.
//
//   Parameter
//     GATE_W      width of the gate-length load value
//
//   Signals (direction as seen by the controller, modport slave)
//     i_start     in   start a measurement (level, sampled in IDLE)
//     i_abort     in   abandon the measurement, return to IDLE
//     i_gate_len  in   gate length in sysclk cycles, sampled in CLEAR
//     i_ic_flg    in   counter incremented on the edge that produced i_cnt_data
//     i_cnt_data  in   current 16-bit counter value
//     o_clr       out  counter clear
//     o_cnt_en    out  counter enable
//     o_busy      out  high in every state except IDLE
//     o_done      out  one-cycle pulse; o_result/o_ovf valid
//     o_result    out  edge count of the last completed measurement
//     o_ovf       out  counter wrapped during the last completed measurement
//
//   Modports
//     master      register/CPU side plus counter model: drives the i_* signals
//     slave       the gate controller: drives the o_* signals
// ---------------------------------------------------------------------------
interface ic_gate_ctrl_if #(
  parameter int GATE_W = 24
);

  logic              i_start;
  logic              i_abort;
  logic [GATE_W-1:0] i_gate_len;
  logic              i_ic_flg;
  logic [15:0]       i_cnt_data;

  logic              o_clr;
  logic              o_cnt_en;
  logic              o_busy;
  logic              o_done;
  logic [15:0]       o_result;
  logic              o_ovf;

  modport master (
    output i_start,
    output i_abort,
    output i_gate_len,
    output i_ic_flg,
    output i_cnt_data,
    input  o_clr,
    input  o_cnt_en,
    input  o_busy,
    input  o_done,
    input  o_result,
    input  o_ovf
  );

  modport slave (
    input  i_start,
    input  i_abort,
    input  i_gate_len,
    input  i_ic_flg,
    input  i_cnt_data,
    output o_clr,
    output o_cnt_en,
    output o_busy,
    output o_done,
    output o_result,
    output o_ovf
  );

endinterface : ic_gate_ctrl_if

// File: rtl/ic_gate_ctrl.sv
// ---------------------------------------------------------------------------
// ic_gate_ctrl
//   Gate-time sequencer for the 16-bit input capture counter. A start request
//   clears the counter, enables it for a programmed number of sysclk cycles,
//   allows one cycle for the last increment to land, then latches the count
//   and the wrap flag and pulses o_done. This block is the only driver of the
//   counter's clear and enable.
//
//   Sequence: IDLE -> CLEAR -> GATE (N cycles, skipped for N = 0)
//             -> SETTLE -> DONE -> IDLE
//   A start sampled at edge t gives o_clr for one cycle after t, o_cnt_en for
//   the N cycles after that, and o_done N+2 cycles after t.
//
//   Ports
//     i_sysclk    system clock, everything on the rising edge
//     i_sysrst    synchronous active-high reset, wins over every other input
//     bus         ic_gate_ctrl_if.slave (request, counter feedback, outputs)
//
//   Parameter
//     GATE_W      width of the gate-length load value and gate down-counter;
//                 longest gate is 2^GATE_W-1 cycles, so the counter never wraps
//
//   Build option
//     IC_GATE_CONT_EN  when defined, DONE goes straight back to CLEAR: the
//                      measurement repeats with i_gate_len resampled each
//                      round, o_busy stays high and only i_abort or reset
//                      return to IDLE. When undefined, each measurement needs
//                      its own i_start.
// ---------------------------------------------------------------------------
module ic_gate_ctrl #(
  parameter int GATE_W = 24
) (
  input  logic          i_sysclk,
  input  logic          i_sysrst,
  ic_gate_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GATE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [GATE_W-1:0] gate_ctr_q;   // remaining gate cycles, including the current one
  logic              ovf_acc_q;    // sticky wrap seen during this measurement
  logic              clr_q;
  logic              cnt_en_q;
  logic              busy_q;
  logic              done_q;
  logic [15:0]       result_q;
  logic              ovf_q;
  logic              wrap_hit;

  // The counter reports an increment together with the value it produced;
  // an increment that produced zero means the counter rolled over 0xFFFF->0.
  // SETTLE is included because the last gate cycle's increment shows up there.
  assign wrap_hit = ((state_q == ST_GATE) || (state_q == ST_SETTLE)) &&
                    bus.i_ic_flg && (bus.i_cnt_data == 16'h0000);

  // -------------------------------------------------------------------------
  // Next-state decode. Abort overrides every non-IDLE state. In IDLE a start
  // that arrives together with abort is dropped.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first, so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    if ((state_q != ST_IDLE) && bus.i_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_start && !bus.i_abort) begin
            state_d = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          // A zero-length gate never enables the counter; result will be 0.
          state_d = (bus.i_gate_len == '0) ? ST_SETTLE : ST_GATE;
        end
        ST_GATE: begin
          if (gate_ctr_q == GATE_W'(1)) begin
            state_d = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          state_d = ST_DONE;
        end
        ST_DONE: begin
`ifdef IC_GATE_CONT_EN
          state_d = ST_CLEAR;
`else
          state_d = ST_IDLE;
`endif
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State, datapath and registered outputs. Outputs are decoded from state_d
  // so they change on the same edge as the state they belong to; an abort
  // therefore drops o_clr/o_cnt_en on the edge that returns to IDLE.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      state_q    <= ST_IDLE;
      gate_ctr_q <= '0;
      ovf_acc_q  <= 1'b0;
      clr_q      <= 1'b0;
      cnt_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 16'h0000;
      ovf_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      clr_q    <= (state_d == ST_CLEAR);
      cnt_en_q <= (state_d == ST_GATE);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);

      case (state_q)
        ST_CLEAR: begin
          // Gate length is captured here only; later changes do not affect
          // the measurement in progress.
          gate_ctr_q <= bus.i_gate_len;
          ovf_acc_q  <= 1'b0;
        end
        ST_GATE: begin
          gate_ctr_q <= gate_ctr_q - GATE_W'(1);
          if (wrap_hit) begin
            ovf_acc_q <= 1'b1;
          end
        end
        ST_SETTLE: begin
          // The counter is final during SETTLE, so the result is captured on
          // the edge into DONE and is valid together with o_done. An abort in
          // SETTLE leaves the previous result untouched.
          if (state_d == ST_DONE) begin
            result_q <= bus.i_cnt_data;
            ovf_q    <= ovf_acc_q | wrap_hit;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_clr    = clr_q;
  assign bus.o_cnt_en = cnt_en_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_done   = done_q;
  assign bus.o_result = result_q;
  assign bus.o_ovf    = ovf_q;

endmodule : ic_gate_ctrl
